// File: rtl/load_store_unit_if.sv
// load_store_unit_if: req/ack data-memory bus between the load/store unit and memory.
interface load_store_unit_if #(parameter int n = 32);
  logic         mem_req;
  logic         mem_we;
  logic [n-1:0] mem_addr;
  logic [3:0]   mem_wstrb;
  logic [n-1:0] mem_wdata;
  logic         mem_ack;
  logic [n-1:0] mem_rdata;
  modport master(output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata, input mem_ack, mem_rdata);
  modport slave(input mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata, output mem_ack, mem_rdata);
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I memory stage, one load/store at a time over a req/ack bus.
// Optional REQ timeout (fault_code 3) when LSU_TIMEOUT_EN is defined.
module load_store_unit #(
  parameter int n = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_start,
  input  logic                      i_is_load,
  input  logic                      i_is_store,
  input  logic [2:0]                i_funct3,
  input  logic [n-1:0]              i_addr,
  input  logic [n-1:0]              i_store_data,
  load_store_unit_if.master         i_bus,
  output logic                      o_busy,
  output logic                      o_done,
  output logic [n-1:0]              o_load_data,
  output logic                      o_fault,
  output logic [1:0]                o_fault_code
);
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must fit the 8-bit REQ counter");
  end
  state_t       r_state, w_next;
  logic         r_mem_req, r_mem_we, r_done, r_fault;
  logic [3:0]   r_mem_wstrb;
  logic [n-1:0] r_mem_addr, r_mem_wdata, r_load_data;
  logic [1:0]   r_fault_code, r_code, r_off;
  logic [2:0]   r_f3;
  logic         w_acc, w_ldok, w_stok, w_illegal, w_mis, w_to;
  logic [1:0]   w_code;
  logic [3:0]   w_strb;
  logic [n-1:0] w_wdata, w_lane, w_ext;
`ifdef LSU_TIMEOUT_EN
  logic [7:0]   r_cnt;
`endif
  assign i_bus.mem_req   = r_mem_req;
  assign i_bus.mem_we    = r_mem_we;
  assign i_bus.mem_addr  = r_mem_addr;
  assign i_bus.mem_wstrb = r_mem_wstrb;
  assign i_bus.mem_wdata = r_mem_wdata;
  assign o_busy          = r_state != IDLE;
  assign o_done          = r_done;
  assign o_load_data     = r_load_data;
  assign o_fault         = r_fault;
  assign o_fault_code    = r_fault_code;
  always_comb begin
    w_acc     = i_start && (i_is_load || i_is_store);
    w_ldok    = i_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    w_stok    = i_funct3 inside {3'b000, 3'b001, 3'b010};
    w_illegal = (i_is_load && i_is_store) || (i_is_load ? !w_ldok : !w_stok);
    w_mis     = (i_funct3[1:0] == 2'b01 && i_addr[0]) || (i_funct3[1:0] == 2'b10 && i_addr[1:0] != 2'b00);
    w_code    = w_illegal ? 2'd2 : w_mis ? 2'd1 : 2'd0;
    w_strb    = i_funct3[1:0] == 2'b00 ? 4'b0001 << i_addr[1:0] :
                i_funct3[1:0] == 2'b01 ? 4'b0011 << {i_addr[1], 1'b0} : 4'b1111;
    w_wdata   = i_funct3[1:0] == 2'b00 ? {4{i_store_data[7:0]}} :
                i_funct3[1:0] == 2'b01 ? {2{i_store_data[15:0]}} : i_store_data;
    w_lane    = i_bus.mem_rdata >> {r_off, 3'b000};
    w_ext     = r_f3[1:0] == 2'b00 ? {{24{!r_f3[2] && w_lane[7]}}, w_lane[7:0]} :
                r_f3[1:0] == 2'b01 ? {{16{!r_f3[2] && w_lane[15]}}, w_lane[15:0]} : w_lane;
`ifdef LSU_TIMEOUT_EN
    w_to      = !i_bus.mem_ack && r_cnt == 8'(TIMEOUT_CYCLES - 1);
`else
    w_to      = 1'b0;
`endif
    w_next    = r_state == IDLE ? (w_acc ? (w_code != 2'd0 ? DONE : REQ) : IDLE) :
                r_state == REQ  ? ((i_bus.mem_ack || w_to) ? DONE : REQ) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wstrb  <= 4'b0;
      r_mem_wdata  <= '0;
      r_done       <= 1'b0;
      r_fault      <= 1'b0;
      r_fault_code <= 2'd0;
      r_load_data  <= '0;
      r_code       <= 2'd0;
      r_off        <= 2'd0;
      r_f3         <= 3'd0;
`ifdef LSU_TIMEOUT_EN
      r_cnt        <= 8'd0;
`endif
    end else begin
      r_state      <= w_next;
      r_done       <= r_state == DONE;
      r_fault      <= r_state == DONE && r_code != 2'd0;
      r_fault_code <= r_state == DONE ? r_code : 2'd0;
      if (r_state == IDLE && w_acc) begin
        r_code      <= w_code;
        r_off       <= i_addr[1:0];
        r_f3        <= i_funct3;
        r_mem_req   <= w_code == 2'd0;
        r_mem_we    <= w_code == 2'd0 && i_is_store;
        r_mem_addr  <= {i_addr[n-1:2], 2'b00};
        r_mem_wstrb <= (w_code == 2'd0 && i_is_store) ? w_strb : 4'b0;
        r_mem_wdata <= i_is_store ? w_wdata : '0;
      end else if (r_state == REQ && (i_bus.mem_ack || w_to)) begin
        r_mem_req   <= 1'b0;
        r_mem_we    <= 1'b0;
        r_mem_wstrb <= 4'b0;
        r_code      <= i_bus.mem_ack ? 2'd0 : 2'd3;
        if (i_bus.mem_ack && !r_mem_we) r_load_data <= w_ext;
      end
`ifdef LSU_TIMEOUT_EN
      r_cnt <= r_state == IDLE ? 8'd0 : (r_state == REQ && !i_bus.mem_ack) ? r_cnt + 8'd1 : r_cnt;
`endif
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed self-checking bench for load_store_unit.
module tb_load_store_unit;
  localparam int TO = 4;
  logic        clk = 1'b0, rst = 1'b1;
  logic        start = 1'b0, is_load = 1'b0, is_store = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] addr = '0, store_data = '0;
  logic        busy, done, fault;
  logic [31:0] load_data;
  logic [1:0]  fault_code;
  logic [31:0] last_load;
  int          errors = 0, checks = 0;
  load_store_unit_if #(.n(32)) bus();
  load_store_unit #(.n(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .i_start(start), .i_is_load(is_load), .i_is_store(is_store),
    .i_funct3(funct3), .i_addr(addr), .i_store_data(store_data), .i_bus(bus.master),
    .o_busy(busy), .o_done(done), .o_load_data(load_data), .o_fault(fault), .o_fault_code(fault_code)
  );
  always #5 clk = ~clk;
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic start_op(input logic ld, input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] sd);
    start = 1'b1; is_load = ld; is_store = st; funct3 = f3; addr = a; store_data = sd;
    step;
    start = 1'b0; is_load = 1'b0; is_store = 1'b0;
  endtask
  task automatic ack_op(input logic [31:0] rd);
    bus.mem_ack = 1'b1; bus.mem_rdata = rd;
    step;
    bus.mem_ack = 1'b0;
  endtask
  task automatic test_reset;
    rst = 1'b1; bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    step; step;
    rst = 1'b0;
    checks++;
    if ({busy, done, fault, fault_code, bus.mem_req, bus.mem_we, bus.mem_wstrb} !== 11'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b want 0", {busy, done, fault, fault_code, bus.mem_req, bus.mem_we, bus.mem_wstrb});
    end
    checks++;
    if ({load_data, bus.mem_addr, bus.mem_wdata} !== 96'b0) begin
      errors++; $display("FAIL reset_data: load_data=%h mem_addr=%h mem_wdata=%h want 0", load_data, bus.mem_addr, bus.mem_wdata);
    end
    last_load = 32'h0;
  endtask
  task automatic test_lw;
    start_op(1'b1, 1'b0, 3'b010, 32'h100, 32'h0);
    checks++;
    if ({bus.mem_req, bus.mem_we, bus.mem_wstrb, bus.mem_addr, busy} !== {1'b1, 1'b0, 4'b0, 32'h100, 1'b1}) begin
      errors++; $display("FAIL lw_req: req=%b we=%b wstrb=%b addr=%h busy=%b want 1 0 0000 00000100 1", bus.mem_req, bus.mem_we, bus.mem_wstrb, bus.mem_addr, busy);
    end
    step; step;
    checks++;
    if ({bus.mem_req, done, bus.mem_addr} !== {1'b1, 1'b0, 32'h100}) begin
      errors++; $display("FAIL lw_wait: req=%b done=%b addr=%h want 1 0 00000100", bus.mem_req, done, bus.mem_addr);
    end
    ack_op(32'hDEADBEEF);
    checks++;
    if ({load_data, bus.mem_req, done} !== {32'hDEADBEEF, 1'b0, 1'b0}) begin
      errors++; $display("FAIL lw_ack: load_data=%h req=%b done=%b want deadbeef 0 0", load_data, bus.mem_req, done);
    end
    step;
    checks++;
    if ({done, fault, fault_code} !== 4'b1000) begin
      errors++; $display("FAIL lw_done: done/fault/code=%b want 1000", {done, fault, fault_code});
    end
    step;
    checks++;
    if ({done, busy} !== 2'b00) begin
      errors++; $display("FAIL lw_pulse: done=%b busy=%b want 0 0", done, busy);
    end
    last_load = 32'hDEADBEEF;
  endtask
  task automatic test_load_ext;
    logic [2:0]  f3s [5];
    logic [31:0] as [5];
    logic [31:0] exps [5];
    f3s  = '{3'b000, 3'b100, 3'b101, 3'b001, 3'b000};
    as   = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h100};
    exps = '{32'hFFFFFF80, 32'h00000080, 32'h00008012, 32'hFFFF8012, 32'h00000056};
    for (int i = 0; i < 5; i++) begin
      start_op(1'b1, 1'b0, f3s[i], as[i], 32'h0);
      ack_op(32'h80123456);
      step;
      checks++;
      if ({done, fault, load_data} !== {1'b1, 1'b0, exps[i]}) begin
        errors++; $display("FAIL load_ext%0d: done=%b fault=%b load_data=%h want 1 0 %h", i, done, fault, load_data, exps[i]);
      end
      step;
      last_load = exps[i];
    end
  endtask
  task automatic test_store;
    logic [2:0]  f3s [3];
    logic [31:0] as [3];
    logic [31:0] sds [3];
    logic [3:0]  strbs [3];
    logic [31:0] wds [3];
    logic [31:0] was [3];
    f3s   = '{3'b000, 3'b001, 3'b010};
    as    = '{32'h201, 32'h202, 32'h204};
    sds   = '{32'h000000A5, 32'h1234BEEF, 32'h12345678};
    strbs = '{4'b0010, 4'b1100, 4'b1111};
    wds   = '{32'hA5A5A5A5, 32'hBEEFBEEF, 32'h12345678};
    was   = '{32'h200, 32'h200, 32'h204};
    for (int i = 0; i < 3; i++) begin
      start_op(1'b0, 1'b1, f3s[i], as[i], sds[i]);
      checks++;
      if ({bus.mem_req, bus.mem_we, bus.mem_wstrb, bus.mem_wdata, bus.mem_addr} !== {1'b1, 1'b1, strbs[i], wds[i], was[i]}) begin
        errors++; $display("FAIL store%0d_bus: req=%b we=%b wstrb=%b wdata=%h addr=%h want 1 1 %b %h %h",
                           i, bus.mem_req, bus.mem_we, bus.mem_wstrb, bus.mem_wdata, bus.mem_addr, strbs[i], wds[i], was[i]);
      end
      ack_op(32'hFFFFFFFF);
      checks++;
      if ({bus.mem_req, bus.mem_we, bus.mem_wstrb} !== 6'b0) begin
        errors++; $display("FAIL store%0d_release: req/we/wstrb=%b want 000000", i, {bus.mem_req, bus.mem_we, bus.mem_wstrb});
      end
      step;
      checks++;
      if ({done, fault, load_data} !== {1'b1, 1'b0, last_load}) begin
        errors++; $display("FAIL store%0d_done: done=%b fault=%b load_data=%h want 1 0 %h", i, done, fault, load_data, last_load);
      end
      step;
    end
  endtask
  task automatic test_fault;
    logic        lds [7];
    logic        sts [7];
    logic [2:0]  f3s [7];
    logic [31:0] as [7];
    logic [1:0]  codes [7];
    lds   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    sts   = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    f3s   = '{3'b010, 3'b011, 3'b010, 3'b001, 3'b100, 3'b001, 3'b110};
    as    = '{32'h102, 32'h100, 32'h100, 32'h201, 32'h200, 32'h103, 32'h100};
    codes = '{2'd1, 2'd2, 2'd2, 2'd1, 2'd2, 2'd1, 2'd2};
    for (int i = 0; i < 7; i++) begin
      start_op(lds[i], sts[i], f3s[i], as[i], 32'h55);
      checks++;
      if ({bus.mem_req, busy, done} !== 3'b010) begin
        errors++; $display("FAIL fault%0d_first: req=%b busy=%b done=%b want 0 1 0", i, bus.mem_req, busy, done);
      end
      step;
      checks++;
      if ({done, fault, fault_code, bus.mem_req, load_data} !== {1'b1, 1'b1, codes[i], 1'b0, last_load}) begin
        errors++; $display("FAIL fault%0d_done: done=%b fault=%b code=%0d req=%b load_data=%h want 1 1 %0d 0 %h",
                           i, done, fault, fault_code, bus.mem_req, load_data, codes[i], last_load);
      end
      step;
    end
  endtask
  task automatic test_ignore;
    start_op(1'b0, 1'b0, 3'b010, 32'h100, 32'h0);
    checks++;
    if ({busy, bus.mem_req} !== 2'b00) begin
      errors++; $display("FAIL ignore_noflag: busy=%b req=%b want 0 0", busy, bus.mem_req);
    end
    ack_op(32'h12345678);
    step;
    checks++;
    if ({busy, done, bus.mem_req, load_data} !== {3'b000, last_load}) begin
      errors++; $display("FAIL ignore_idle_ack: busy=%b done=%b req=%b load_data=%h want 0 0 0 %h", busy, done, bus.mem_req, load_data, last_load);
    end
  endtask
  task automatic test_back_to_back;
    start_op(1'b1, 1'b0, 3'b010, 32'h300, 32'h0);
    ack_op(32'h11111111);
    start_op(1'b1, 1'b0, 3'b010, 32'h400, 32'h0);
    checks++;
    if ({busy, done, bus.mem_req, load_data} !== {3'b010, 32'h11111111}) begin
      errors++; $display("FAIL b2b_done_ignore: busy=%b done=%b req=%b load_data=%h want 0 1 0 11111111", busy, done, bus.mem_req, load_data);
    end
    start_op(1'b1, 1'b0, 3'b010, 32'h304, 32'h0);
    checks++;
    if ({bus.mem_req, bus.mem_addr} !== {1'b1, 32'h304}) begin
      errors++; $display("FAIL b2b_second_req: req=%b addr=%h want 1 00000304", bus.mem_req, bus.mem_addr);
    end
    ack_op(32'h22222222);
    step;
    checks++;
    if ({done, load_data} !== {1'b1, 32'h22222222}) begin
      errors++; $display("FAIL b2b_second_done: done=%b load_data=%h want 1 22222222", done, load_data);
    end
    step;
    last_load = 32'h22222222;
  endtask
  task automatic test_reset_mid;
    logic seen_done;
    start_op(1'b1, 1'b0, 3'b010, 32'h500, 32'h0);
    step;
    rst = 1'b1;
    step;
    rst = 1'b0;
    checks++;
    if ({bus.mem_req, busy, done, load_data} !== 35'b0) begin
      errors++; $display("FAIL reset_mid: req=%b busy=%b done=%b load_data=%h want 0 0 0 0", bus.mem_req, busy, done, load_data);
    end
    seen_done = 1'b0;
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h99999999;
    for (int i = 0; i < 3; i++) begin
      step;
      seen_done |= done;
    end
    bus.mem_ack = 1'b0;
    checks++;
    if ({seen_done, busy} !== 2'b00) begin
      errors++; $display("FAIL reset_mid_nodone: done_seen=%b busy=%b want 0 0", seen_done, busy);
    end
    start_op(1'b1, 1'b0, 3'b010, 32'h104, 32'h0);
    ack_op(32'hCAFEF00D);
    step;
    checks++;
    if ({done, fault, load_data} !== {2'b10, 32'hCAFEF00D}) begin
      errors++; $display("FAIL reset_mid_after: done=%b fault=%b load_data=%h want 1 0 cafef00d", done, fault, load_data);
    end
    step;
    last_load = 32'hCAFEF00D;
  endtask
`ifdef LSU_TIMEOUT_EN
  task automatic test_timeout;
    int cyc;
    start_op(1'b1, 1'b0, 3'b010, 32'h600, 32'h0);
    cyc = 0;
    while (bus.mem_req && cyc < 50) begin
      cyc++;
      step;
    end
    checks++;
    if (cyc !== TO) begin
      errors++; $display("FAIL timeout_req_cycles: got %0d want %0d", cyc, TO);
    end
    step;
    checks++;
    if ({done, fault, fault_code, load_data} !== {1'b1, 1'b1, 2'd3, last_load}) begin
      errors++; $display("FAIL timeout_done: done=%b fault=%b code=%0d load_data=%h want 1 1 3 %h", done, fault, fault_code, load_data, last_load);
    end
    step;
  endtask
`endif
  initial begin
    test_reset;
    test_lw;
    test_load_ext;
    test_store;
    test_fault;
    test_ignore;
    test_back_to_back;
    test_reset_mid;
`ifdef LSU_TIMEOUT_EN
    test_timeout;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-stage block of the KLP32 pipeline. Sits between the ALU, which supplies the effective address, and the writeback mux, which receives `load_data` on its `mem_in` input.
- Executes one RV32I load or store at a time over a simple req/ack data-memory bus.
- Handles byte-lane steering, write strobes, sign/zero extension, misalignment detection and a completion handshake.
- Stalls the pipeline via `busy` while a transaction is outstanding.

Parameters:
- n, 32, data/address width (only 32 supported; byte-lane logic assumes 4 lanes)
- TIMEOUT_CYCLES, 16, max cycles in REQ waiting for `mem_ack` (used only with LSU_TIMEOUT_EN)

Ports:
- clk  in  1  clock, rising edge; single clock domain
- rst  in  1  synchronous, active-high reset
- start  in  1  request valid; sampled only in IDLE
- is_load  in  1  operation is a load
- is_store  in  1  operation is a store
- funct3  in  3  RV32I size/sign code
- addr  in  n  effective byte address from ALU
- store_data  in  n  rs2 value
- mem_req  out  1  bus request
- mem_we  out  1  1 = write
- mem_addr  out  n  word-aligned address `{addr[n-1:2],2'b00}`
- mem_wstrb  out  4  byte write enables
- mem_wdata  out  n  lane-replicated write data
- mem_ack  in  1  bus completion; read data valid in the same cycle
- mem_rdata  in  n  read word
- busy  out  1  `state != IDLE`
- done  out  1  one-cycle completion pulse
- load_data  out  n  extended load result
- fault  out  1  operation completed abnormally (valid with `done`)
- fault_code  out  2  0 none, 1 misaligned, 2 illegal, 3 timeout

Behaviour:
- FSM states: IDLE, REQ, DONE. All outputs are registered.
- Reset (synchronous, highest priority): state=IDLE; every output = 0.
  - Asserting `rst` mid-transaction aborts it: `mem_req` is 0 after that edge and no `done` is produced.
- IDLE:
  - `start=1` with exactly one of `is_load`/`is_store` set: latch `addr`, `funct3`, `store_data`.
  - Legality check on the latched op:
    - Loads: funct3 ∈ {000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU}.
    - Stores: funct3 ∈ {000 SB, 001 SH, 010 SW}.
    - Illegal funct3, or `is_load` and `is_store` both 1 -> DONE with fault_code=2.
  - Alignment check: halfword needs `addr[0]=0`; word needs `addr[1:0]=0`. Violation -> DONE with fault_code=1.
  - Illegal and misaligned ops never raise `mem_req`.
  - Otherwise -> REQ.
  - `start=1` with neither flag set is ignored.
- REQ:
  - `mem_req=1`; `mem_we=is_store`.
  - `mem_addr`, `mem_wstrb` and `mem_wdata` are held stable until `mem_ack` is seen.
  - Write strobes:
    - SB: `4'b0001 << addr[1:0]`
    - SH: `4'b0011 << {addr[1],1'b0}`
    - SW: `4'b1111`
    - Loads: `4'b0000`
  - Write data: SB replicates byte[7:0] x4; SH replicates half[15:0] x2; SW passes the word through.
  - On `mem_ack=1`:
    - Loads: select the lane by `addr[1:0]`, then sign-extend (LB/LH) or zero-extend (LBU/LHU) into `load_data`.
    - Transition to DONE; `mem_req`, `mem_we` and `mem_wstrb` return to 0 on that edge.
  - `mem_ack` seen in IDLE or DONE is ignored.
- DONE:
  - `done=1` for exactly one cycle; `fault`/`fault_code` are valid only in this cycle, 0 otherwise.
  - -> IDLE.
  - `start` in DONE is ignored because `busy=1`.
- `load_data` holds its value until the next successful load completes. Stores and faulted ops leave it unchanged.
- Latency:
  - `start` accepted at edge T -> `mem_req` high after T.
  - With a zero-wait ack, `done` is high after T+2.
  - Back-to-back throughput is one op per 3 cycles.
  - Faulted ops: `done` is high after T+1.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on REQ entry and increments each REQ cycle without ack.
  - When it reaches TIMEOUT_CYCLES: drop `mem_req` and go to DONE with fault=1, fault_code=3; `load_data` is unchanged.
  - An ack in the same cycle as the limit wins, giving normal completion.
- Undefined: REQ waits indefinitely; fault_code=3 is never produced and no counter is built.

Test Plan:
- LW, addr=0x100, mem_rdata=0xDEADBEEF, ack after 2 wait cycles -> mem_addr=0x100, wstrb=0, `done` pulses once, load_data=0xDEADBEEF, fault=0.
- LB, addr=0x103, rdata=0x80123456 -> load_data=0xFFFFFF80. LBU at the same address -> 0x00000080. LHU at addr=0x102 -> 0x00008012.
- SB, addr=0x201, store_data=0x000000A5 -> mem_we=1, wstrb=0010, wdata=0xA5A5A5A5, mem_addr=0x200. SH at addr=0x202 -> wstrb=1100.
- LW at addr=0x102 -> no `mem_req` ever; `done` one cycle later with fault=1, fault_code=1. LD (funct3=011) -> fault_code=2.
- Reset asserted while in REQ before ack -> next cycle mem_req=0, busy=0, no `done`. A new LW afterwards completes normally.
- With LSU_TIMEOUT_EN, TIMEOUT_CYCLES=4, ack held at 0 -> `mem_req` high exactly 4 cycles, then `done` with fault_code=3 and load_data unchanged.
